// File: rtl/nnrv_pkg.sv
// Shared constants and helpers for the nnrv memory-arbiter slice.
package nnrv_pkg;

    // Arbitration modes
    localparam int unsigned PRIO_FIXED = 0;
    localparam int unsigned PRIO_RR    = 1;

    // Index width that stays legal for a single-channel build
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nnrv_rr_arb.sv
// Request arbiter: fixed priority (channel 0 highest) or round-robin with a
// priority pointer that moves past the last granted channel.
module nnrv_rr_arb
    import nnrv_pkg::*;
#(
    parameter int unsigned NCH  = 2,
    parameter int unsigned MODE = PRIO_FIXED,
    localparam int unsigned IW  = ptr_width(NCH)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [NCH-1:0] req,
    input  logic           advance,
    output logic [NCH-1:0] grant,
    output logic [IW-1:0]  grant_idx
);

    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] next_ptr;
    int unsigned   start_pos;
    int unsigned   cand;
    logic          found;

    // Search upward from the start position, wrapping at NCH
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        start_pos = (MODE == PRIO_RR) ? 32'(rr_ptr) : 0;
        for (int unsigned k = 0; k < NCH; k++) begin
            cand = start_pos + k;
            if (cand >= NCH) begin
                cand = cand - NCH;
            end
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = IW'(cand);
            end
        end
    end

    // Next pointer is one past the winner, modulo NCH
    always_comb begin
        next_ptr = (32'(grant_idx) >= NCH - 1) ? '0 : grant_idx + IW'(1);
    end

    // Pointer advances only on a completed transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (MODE == PRIO_RR && advance) begin
            rr_ptr <= next_ptr;
        end
    end

endmodule

// File: rtl/nnrv_mem_arb.sv
// N-channel arbiter in front of a single-port byte-masked RAM. Grants are
// combinational; each transfer returns a tagged one-cycle response pulse.
module nnrv_mem_arb
    import nnrv_pkg::*;
#(
    parameter int unsigned NCH        = 2,
    parameter int unsigned XLEN       = 64,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned MASK_WIDTH = XLEN / 8,
    parameter int unsigned PRIO_MODE  = PRIO_FIXED
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [NCH-1:0]             i_req_valid,
    output logic [NCH-1:0]             o_req_ready,
    input  logic [NCH-1:0]             i_req_we,
    input  logic [NCH*ADDR_WIDTH-1:0]  i_req_addr,
    input  logic [NCH*MASK_WIDTH-1:0]  i_req_mask,
    input  logic [NCH*XLEN-1:0]        i_req_wdata,
    output logic [NCH-1:0]             o_rsp_valid,
    output logic [XLEN-1:0]            o_rsp_rdata,
    output logic                       o_ram_en,
    output logic                       o_ram_we,
    output logic [ADDR_WIDTH-1:0]      o_ram_addr,
    output logic [MASK_WIDTH-1:0]      o_ram_mask,
    output logic [XLEN-1:0]            o_ram_wdata,
    input  logic [XLEN-1:0]            i_ram_rdata
);

    localparam int unsigned IW = ptr_width(NCH);

    logic                  run_q;
    logic [NCH-1:0]        req_gated;
    logic [NCH-1:0]        grant;
    logic [IW-1:0]         grant_idx;
    logic                  xfer;
    logic [31:0]           sel;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [MASK_WIDTH-1:0] sel_mask;
    logic [XLEN-1:0]       sel_wdata;
    logic [NCH-1:0]        rsp_valid_q;
    logic                  rsp_we_q;
    logic [MASK_WIDTH-1:0] rsp_mask_q;
    logic [XLEN-1:0]       rd_mask;

    // Run flag keeps grants off until the first edge after reset release
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    assign req_gated = i_req_valid & {NCH{run_q}};

    nnrv_rr_arb #(
        .NCH  (NCH),
        .MODE (PRIO_MODE)
    ) u_arb (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .req       (req_gated),
        .advance   (xfer),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // A grant is only ever issued to a valid channel, so grant implies transfer
    assign xfer        = |grant;
    assign o_req_ready = grant;

    // Payload mux from the granted channel's slices
    always_comb begin
        sel       = 32'(grant_idx);
        sel_we    = i_req_we[sel];
        sel_addr  = i_req_addr[sel*ADDR_WIDTH +: ADDR_WIDTH];
        sel_mask  = i_req_mask[sel*MASK_WIDTH +: MASK_WIDTH];
        sel_wdata = i_req_wdata[sel*XLEN +: XLEN];
    end

    // RAM command, held at zero whenever there is no transfer
    always_comb begin
        o_ram_en    = xfer;
        o_ram_we    = xfer & sel_we;
        o_ram_addr  = xfer ? sel_addr : '0;
        o_ram_mask  = xfer ? sel_mask : '0;
        o_ram_wdata = xfer ? sel_wdata : '0;
    end

    // Response tag: owning channel, write flag and mask of the transfer
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rsp_valid_q <= '0;
            rsp_we_q    <= 1'b0;
            rsp_mask_q  <= '0;
        end else begin
            rsp_valid_q <= grant;
            rsp_we_q    <= xfer & sel_we;
            rsp_mask_q  <= xfer ? sel_mask : '0;
        end
    end

    // Expand the registered byte mask to bit granularity
    always_comb begin
        rd_mask = '0;
        for (int unsigned b = 0; b < MASK_WIDTH; b++) begin
            rd_mask[b*8 +: 8] = {8{rsp_mask_q[b]}};
        end
    end

    // Read data is masked; writes and idle cycles return zero
    always_comb begin
        o_rsp_valid = rsp_valid_q;
        o_rsp_rdata = ((|rsp_valid_q) && !rsp_we_q) ? (i_ram_rdata & rd_mask) : '0;
    end

endmodule

// File: tb/tb_nnrv_mem_arb.sv
// Bench for nnrv_mem_arb: a fixed-priority and a round-robin instance (NCH=4)
// driven with identical stimulus, each against its own RAM model.
module tb_nnrv_mem_arb;

    localparam int NC = 4;
    localparam int AW = 10;
    localparam int MW = 8;
    localparam int XL = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NC-1:0]    valid;
    logic [NC-1:0]    we;
    logic [AW-1:0]    addr_c  [NC];
    logic [MW-1:0]    mask_c  [NC];
    logic [XL-1:0]    wdata_c [NC];
    logic [NC*AW-1:0] addr_bus;
    logic [NC*MW-1:0] mask_bus;
    logic [NC*XL-1:0] wdata_bus;

    logic [NC-1:0] ready     [2];
    logic [NC-1:0] rsp_valid [2];
    logic [XL-1:0] rsp_rdata [2];
    logic          ram_en    [2];
    logic          ram_we    [2];
    logic [AW-1:0] ram_addr  [2];
    logic [MW-1:0] ram_mask  [2];
    logic [XL-1:0] ram_wdata [2];
    logic [XL-1:0] ram_rdata [2];

    always_comb begin
        addr_bus  = '0;
        mask_bus  = '0;
        wdata_bus = '0;
        for (int c = 0; c < NC; c++) begin
            addr_bus[c*AW +: AW]  = addr_c[c];
            mask_bus[c*MW +: MW]  = mask_c[c];
            wdata_bus[c*XL +: XL] = wdata_c[c];
        end
    end

    nnrv_mem_arb #(
        .NCH(NC), .XLEN(XL), .ADDR_WIDTH(AW), .MASK_WIDTH(MW), .PRIO_MODE(0)
    ) u_fix (
        .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(valid), .o_req_ready(ready[0]),
        .i_req_we(we), .i_req_addr(addr_bus), .i_req_mask(mask_bus),
        .i_req_wdata(wdata_bus), .o_rsp_valid(rsp_valid[0]), .o_rsp_rdata(rsp_rdata[0]),
        .o_ram_en(ram_en[0]), .o_ram_we(ram_we[0]), .o_ram_addr(ram_addr[0]),
        .o_ram_mask(ram_mask[0]), .o_ram_wdata(ram_wdata[0]), .i_ram_rdata(ram_rdata[0])
    );

    nnrv_mem_arb #(
        .NCH(NC), .XLEN(XL), .ADDR_WIDTH(AW), .MASK_WIDTH(MW), .PRIO_MODE(1)
    ) u_rr (
        .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(valid), .o_req_ready(ready[1]),
        .i_req_we(we), .i_req_addr(addr_bus), .i_req_mask(mask_bus),
        .i_req_wdata(wdata_bus), .o_rsp_valid(rsp_valid[1]), .o_rsp_rdata(rsp_rdata[1]),
        .o_ram_en(ram_en[1]), .o_ram_we(ram_we[1]), .o_ram_addr(ram_addr[1]),
        .o_ram_mask(ram_mask[1]), .o_ram_wdata(ram_wdata[1]), .i_ram_rdata(ram_rdata[1])
    );

    function automatic logic [XL-1:0] init_word(input int a);
        if (a == 5) return 64'h1122334455667788;
        if (a == 9) return 64'h0102030405060708;
        return 64'h0123456789ABCDEF ^ (64'(a) * 64'h9E3779B97F4A7C15);
    endfunction

    // RAM models: single port, write commits at the edge, read data one cycle later
    logic [XL-1:0] ram_mem [2][1024];
    logic          loaded = 1'b0;
    always @(posedge clk) begin
        if (!loaded) begin
            for (int m = 0; m < 2; m++) begin
                for (int a = 0; a < 1024; a++) ram_mem[m][a] <= init_word(a);
                ram_rdata[m] <= '0;
            end
            loaded <= 1'b1;
        end else begin
            for (int m = 0; m < 2; m++) begin
                if (ram_en[m] && ram_we[m]) begin
                    for (int b = 0; b < MW; b++) begin
                        if (ram_mask[m][b])
                            ram_mem[m][ram_addr[m]][b*8 +: 8] <= ram_wdata[m][b*8 +: 8];
                    end
                end else if (ram_en[m]) begin
                    ram_rdata[m] <= ram_mem[m][ram_addr[m]];
                end
            end
        end
    end

    // Reference model state
    logic [XL-1:0] shadow [2][1024];
    int            last_g [2];
    bit            run_m;
    int            pend_ch [2];
    logic [XL-1:0] pend_data [2];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [XL-1:0] act, input logic [XL-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [NC-1:0] onehot(input int g);
        logic [NC-1:0] v;
        v = '0;
        if (g >= 0) v[g] = 1'b1;
        return v;
    endfunction

    function automatic logic [XL-1:0] byte_keep(input logic [XL-1:0] d, input logic [MW-1:0] mk);
        logic [XL-1:0] r;
        r = '0;
        for (int b = 0; b < MW; b++) if (mk[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    // Winner: first valid channel scanning upward from the highest-priority one
    function automatic int exp_grant(input int m, input logic [NC-1:0] v);
        int start;
        int c;
        if (!run_m) return -1;
        start = (m == 1) ? (last_g[1] + 1) % NC : 0;
        for (int k = 0; k < NC; k++) begin
            c = (start + k) % NC;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            last_g[m]    = NC - 1;
            pend_ch[m]   = -1;
            pend_data[m] = '0;
        end
        run_m = 1'b0;
    endtask

    // One cycle: inputs already applied after a negedge
    task automatic step(input int efix, input int err, input bit chk_rsp,
                        input logic [XL-1:0] exp_rsp, output logic [NC-1:0] g_both);
        int g [2];
        int tg [2];
        tg[0] = efix;
        tg[1] = err;
        #1;
        for (int m = 0; m < 2; m++) begin
            g[m] = exp_grant(m, valid);
            if (tg[m] != -2) check($sformatf("table_grant[%0d]", m), 64'(ready[m]), 64'(onehot(tg[m])));
            check($sformatf("ready[%0d]", m), 64'(ready[m]), 64'(onehot(g[m])));
            check($sformatf("ram_en[%0d]", m), 64'(ram_en[m]), 64'(g[m] >= 0));
            if (g[m] >= 0) begin
                check($sformatf("ram_we[%0d]", m), 64'(ram_we[m]), 64'(we[g[m]]));
                check($sformatf("ram_addr[%0d]", m), 64'(ram_addr[m]), 64'(addr_c[g[m]]));
                check($sformatf("ram_mask[%0d]", m), 64'(ram_mask[m]), 64'(mask_c[g[m]]));
                check($sformatf("ram_wdata[%0d]", m), ram_wdata[m], wdata_c[g[m]]);
            end else begin
                check($sformatf("ram_we_idle[%0d]", m), 64'(ram_we[m]), 64'd0);
            end
        end
        g_both = onehot(g[0]) & onehot(g[1]);
        @(posedge clk);
        for (int m = 0; m < 2; m++) begin
            pend_ch[m]   = g[m];
            pend_data[m] = '0;
            if (g[m] >= 0) begin
                if (we[g[m]]) begin
                    for (int b = 0; b < MW; b++)
                        if (mask_c[g[m]][b])
                            shadow[m][addr_c[g[m]]][b*8 +: 8] = wdata_c[g[m]][b*8 +: 8];
                end else begin
                    pend_data[m] = byte_keep(shadow[m][addr_c[g[m]]], mask_c[g[m]]);
                end
                last_g[m] = g[m];
            end
        end
        if (rst_n) run_m = 1'b1;
        #1;
        for (int m = 0; m < 2; m++) begin
            check($sformatf("rsp_valid[%0d]", m), 64'(rsp_valid[m]), 64'(onehot(pend_ch[m])));
            check($sformatf("rsp_rdata[%0d]", m), rsp_rdata[m], pend_data[m]);
            if (chk_rsp) check($sformatf("table_rsp[%0d]", m), rsp_rdata[m], exp_rsp);
        end
        @(negedge clk);
    endtask

    task automatic check_quiet(input string tag);
        for (int m = 0; m < 2; m++) begin
            check($sformatf("%s_ready[%0d]", tag, m), 64'(ready[m]), 64'd0);
            check($sformatf("%s_ram_en[%0d]", tag, m), 64'(ram_en[m]), 64'd0);
            check($sformatf("%s_ram_we[%0d]", tag, m), 64'(ram_we[m]), 64'd0);
            check($sformatf("%s_ram_addr[%0d]", tag, m), 64'(ram_addr[m]), 64'd0);
            check($sformatf("%s_rsp_valid[%0d]", tag, m), 64'(rsp_valid[m]), 64'd0);
            check($sformatf("%s_rsp_rdata[%0d]", tag, m), rsp_rdata[m], 64'd0);
        end
    endtask

    task automatic set_all(input logic [NC-1:0] v, input logic [NC-1:0] w, input logic [AW-1:0] a,
                           input logic [MW-1:0] mk, input logic [XL-1:0] d);
        valid = v;
        we    = w;
        for (int c = 0; c < NC; c++) begin
            addr_c[c]  = a;
            mask_c[c]  = mk;
            wdata_c[c] = d;
        end
    endtask

    typedef struct {
        logic [NC-1:0] valid;
        logic [NC-1:0] we;
        logic [AW-1:0] addr;
        logic [MW-1:0] mask;
        logic [XL-1:0] wdata;
        int            exp_fix;
        int            exp_rr;
        bit            chk_rsp;
        logic [XL-1:0] exp_rsp;
    } vec_t;

    vec_t          tbl [$];
    logic [NC-1:0] gb;

    initial begin
        // Directed vectors; round-robin pointer starts at 0 after reset
        tbl.push_back('{4'b0010, 4'b0000, 10'd5, 8'hFF, 64'd0, 1, 1, 1'b1, 64'h1122334455667788});
        tbl.push_back('{4'b0000, 4'b0000, 10'd0, 8'h00, 64'd0, -1, -1, 1'b0, 64'd0});
        tbl.push_back('{4'b0011, 4'b0000, 10'd7, 8'hFF, 64'd0, 0, 0, 1'b0, 64'd0});
        tbl.push_back('{4'b0011, 4'b0000, 10'd7, 8'hFF, 64'd0, 0, 1, 1'b0, 64'd0});
        tbl.push_back('{4'b0011, 4'b0000, 10'd7, 8'hFF, 64'd0, 0, 0, 1'b0, 64'd0});
        tbl.push_back('{4'b0010, 4'b0000, 10'd7, 8'hFF, 64'd0, 1, 1, 1'b0, 64'd0});
        tbl.push_back('{4'b0100, 4'b0000, 10'd8, 8'h3C, 64'd0, 2, 2, 1'b0, 64'd0});
        tbl.push_back('{4'b1000, 4'b0000, 10'd8, 8'hC3, 64'd0, 3, 3, 1'b0, 64'd0});
        for (int i = 0; i < 8; i++)
            tbl.push_back('{4'b1111, 4'b0000, 10'(20 + i), 8'hFF, 64'd0, 0, i % 4, 1'b0, 64'd0});
        tbl.push_back('{4'b0001, 4'b0001, 10'd9, 8'h0F, {8{8'hAA}}, 0, 0, 1'b0, 64'd0});
        tbl.push_back('{4'b0010, 4'b0000, 10'd9, 8'hFF, 64'd0, 1, 1, 1'b1, 64'h01020304AAAAAAAA});
        tbl.push_back('{4'b0000, 4'b0000, 10'd0, 8'h00, 64'd0, -1, -1, 1'b0, 64'd0});

        for (int m = 0; m < 2; m++)
            for (int a = 0; a < 1024; a++) shadow[m][a] = init_word(a);
        model_reset();
        set_all(4'b1111, 4'b0101, 10'd3, 8'hFF, 64'hDEAD);

        // Outputs quiet while held in reset, even with every channel requesting
        repeat (3) @(negedge clk);
        #1;
        check_quiet("in_reset");
        @(negedge clk);
        rst_n = 1'b1;
        set_all(4'b0000, 4'b0000, 10'd0, 8'h00, 64'd0);
        step(-1, -1, 1'b0, 64'd0, gb);

        foreach (tbl[i]) begin
            set_all(tbl[i].valid, tbl[i].we, tbl[i].addr, tbl[i].mask, tbl[i].wdata);
            step(tbl[i].exp_fix, tbl[i].exp_rr, tbl[i].chk_rsp, tbl[i].exp_rsp, gb);
        end

        // Random traffic; a request not granted by both instances is held stable
        valid = '0;
        gb    = '0;
        for (int n = 0; n < 400; n++) begin
            for (int c = 0; c < NC; c++) begin
                if (!valid[c] || gb[c]) begin
                    valid[c]   = ($urandom_range(0, 3) != 0);
                    we[c]      = $urandom_range(0, 1) == 1;
                    addr_c[c]  = 10'($urandom_range(0, 15));
                    mask_c[c]  = 8'($urandom);
                    wdata_c[c] = {$urandom, $urandom};
                end
            end
            step(-2, -2, 1'b0, 64'd0, gb);
        end

        // Reset asserted before the capture edge of a read transfer
        set_all(4'b0010, 4'b0000, 10'd5, 8'hFF, 64'd0);
        #1;
        check("pre_reset_ready_fix", 64'(ready[0]), 64'(4'b0010));
        check("pre_reset_ready_rr", 64'(ready[1]), 64'(4'b0010));
        #2;
        rst_n = 1'b0;
        #1;
        check_quiet("reset_async");
        @(posedge clk);
        #1;
        check_quiet("reset_edge");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        set_all(4'b1111, 4'b0000, 10'd9, 8'hFF, 64'd0);
        step(-1, -1, 1'b0, 64'd0, gb);
        step(0, 0, 1'b0, 64'd0, gb);
        set_all(4'b0000, 4'b0000, 10'd0, 8'h00, 64'd0);
        step(-1, -1, 1'b0, 64'd0, gb);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
